// File: rtl/tcb_gpio_irq.sv
// tcb_gpio_irq: GPIO controller on a TCB subordinate port.
//   Registers: OUT, OE, IN (synchronized pins), OUT_SET/CLR/TGL aliases,
//   IRQ_EN, RISE_EN, FALL_EN, and IRQ_STS (sticky, write-1-to-clear).
//   Read responses (tcb_rdt/tcb_err) are registered one cycle after transfer.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   tcb_vld/rdy     request handshake; rdy is always 1
//   tcb_wen         1 = write, 0 = read
//   tcb_adr         byte address; bits [1:0] ignored
//   tcb_ben/wdt     write byte enables / write data
//   tcb_rdt/err     registered read data / address error flag
//   gpio_o/e/i      pin outputs, output enables, asynchronous pin inputs
//   irq             registered level interrupt (any enabled sticky status bit)
module tcb_gpio_irq #(
  parameter int              GW          = 32,
  parameter int              CFG_CDC     = 2,
  parameter logic [GW-1:0]   CFG_RST_OUT = '0,
  parameter logic [GW-1:0]   CFG_RST_OE  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tcb_vld,
  output logic          tcb_rdy,
  input  logic          tcb_wen,
  input  logic [5:0]    tcb_adr,
  input  logic [3:0]    tcb_ben,
  input  logic [31:0]   tcb_wdt,
  output logic [31:0]   tcb_rdt,
  output logic          tcb_err,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i,
  output logic          irq
);

  if (GW < 1 || GW > 32) begin : g_bad_gw
    $error("tcb_gpio_irq: GW must be in 1..32");
  end
  if (CFG_CDC < 0 || CFG_CDC > 4) begin : g_bad_cdc
    $error("tcb_gpio_irq: CFG_CDC must be in 0..4");
  end

  logic          xfer;
  logic [3:0]    word;
  logic          adr_err;
  logic          wr;
  logic [31:0]   bmask;
  logic [GW-1:0] wmask;
  logic [GW-1:0] wdat;
  logic [GW-1:0] w1c;

  logic [GW-1:0] out_q, oe_q, ien_q, ren_q, fen_q, sts_q;
  logic [GW-1:0] gpio_r, gpio_p;
  logic [GW-1:0] rise, fall;
  logic [GW-1:0] rd_val;
  logic [31:0]   rd_word;

  assign tcb_rdy = 1'b1;
  assign xfer    = tcb_vld & tcb_rdy;
  assign word    = tcb_adr[5:2];
  assign adr_err = (word >= 4'd10);
  assign wr      = xfer & tcb_wen & ~adr_err;

  assign bmask = {{8{tcb_ben[3]}}, {8{tcb_ben[2]}}, {8{tcb_ben[1]}}, {8{tcb_ben[0]}}};
  assign wmask = bmask[GW-1:0];
  assign wdat  = tcb_wdt[GW-1:0];
  assign w1c   = (wr && word == 4'd9) ? (wdat & wmask) : '0;

  // Bits the narrow builds never look at.
  logic unused;
  assign unused = &{1'b0, tcb_adr[1:0], tcb_wdt, bmask};

  function automatic logic [GW-1:0] merge(input logic [GW-1:0] old,
                                          input logic [GW-1:0] din,
                                          input logic [GW-1:0] m);
    return (old & ~m) | (din & m);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= CFG_RST_OUT;
      oe_q  <= CFG_RST_OE;
      ien_q <= '0;
      ren_q <= '0;
      fen_q <= '0;
    end else if (wr) begin
      case (word)
        4'd0: out_q <= merge(out_q, wdat, wmask);
        4'd1: oe_q  <= merge(oe_q, wdat, wmask);
        4'd3: out_q <= out_q | (wdat & wmask);
        4'd4: out_q <= out_q & ~(wdat & wmask);
        4'd5: out_q <= out_q ^ (wdat & wmask);
        4'd6: ien_q <= merge(ien_q, wdat, wmask);
        4'd7: ren_q <= merge(ren_q, wdat, wmask);
        4'd8: fen_q <= merge(fen_q, wdat, wmask);
        default: ;
      endcase
    end
  end

  assign gpio_o = out_q;
  assign gpio_e = oe_q;

  if (CFG_CDC == 0) begin : g_nosync
    assign gpio_r = gpio_i;
  end else begin : g_sync
    logic [GW-1:0] stg [CFG_CDC];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < CFG_CDC; i++) stg[i] <= '0;
      end else begin
        stg[0] <= gpio_i;
        for (int i = 1; i < CFG_CDC; i++) stg[i] <= stg[i-1];
      end
    end
    assign gpio_r = stg[CFG_CDC-1];
  end

  assign rise = gpio_r & ~gpio_p & ren_q;
  assign fall = ~gpio_r & gpio_p & fen_q;

  // Events are ORed in after the clear, so an edge landing on the same
  // cycle as a W1C keeps the status bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_p <= '0;
      sts_q  <= '0;
      irq    <= 1'b0;
    end else begin
      gpio_p <= gpio_r;
      sts_q  <= (sts_q & ~w1c) | rise | fall;
      irq    <= |(sts_q & ien_q);
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      4'd0: rd_val = out_q;
      4'd1: rd_val = oe_q;
      4'd2: rd_val = gpio_r;
      4'd6: rd_val = ien_q;
      4'd7: rd_val = ren_q;
      4'd8: rd_val = fen_q;
      4'd9: rd_val = sts_q;
      default: rd_val = '0;
    endcase
    rd_word = '0;
    rd_word[GW-1:0] = rd_val;
  end

  // Read data holds across writes and idle cycles; the error flag is a
  // one-cycle pulse after any out-of-range transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcb_rdt <= '0;
      tcb_err <= 1'b0;
    end else begin
      tcb_err <= xfer & adr_err;
      if (xfer && !tcb_wen) tcb_rdt <= adr_err ? '0 : rd_word;
    end
  end

endmodule

// File: tb/tb_tcb_gpio_irq.sv
module tb_tcb_gpio_irq;

  localparam int CDC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld, vld8, wen;
  logic [5:0]  adr;
  logic [3:0]  ben;
  logic [31:0] wdt;

  logic        rdy, err, irq;
  logic [31:0] rdt, go, ge, gi;
  logic        rdy8, err8, irq8;
  logic [31:0] rdt8;
  logic [7:0]  go8, ge8, gi8;

  int checks = 0;
  int errors = 0;

  tcb_gpio_irq #(.GW(32), .CFG_CDC(CDC)) dut (
    .clk(clk), .rst(rst),
    .tcb_vld(vld), .tcb_rdy(rdy), .tcb_wen(wen), .tcb_adr(adr),
    .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt), .tcb_err(err),
    .gpio_o(go), .gpio_e(ge), .gpio_i(gi), .irq(irq)
  );

  tcb_gpio_irq #(.GW(8), .CFG_CDC(0)) dut8 (
    .clk(clk), .rst(rst),
    .tcb_vld(vld8), .tcb_rdy(rdy8), .tcb_wen(wen), .tcb_adr(adr),
    .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt8), .tcb_err(err8),
    .gpio_o(go8), .gpio_e(ge8), .gpio_i(gi8), .irq(irq8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [31:0] m_out, m_oe, m_ien, m_ren, m_fen, m_sts, m_rdt, m_prev;
  logic        m_err, m_irq;
  logic [31:0] hist[$];
  logic [31:0] t_cur, t_m, t_d, t_w1c, t_rise, t_fall;
  int          t_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = 0; m_oe = 0; m_ien = 0; m_ren = 0; m_fen = 0; m_sts = 0;
      m_rdt = 0; m_err = 0; m_irq = 0; m_prev = 0;
      hist.delete();
      repeat (CDC) hist.push_front(32'h0);
    end else begin
      t_cur  = hist[CDC-1];
      t_rise = t_cur & ~m_prev & m_ren;
      t_fall = ~t_cur & m_prev & m_fen;
      m_irq  = |(m_sts & m_ien);
      t_w1c  = 0;
      m_err  = 0;
      if (vld) begin
        t_w = int'(adr[5:2]);
        t_m = {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};
        t_d = wdt & t_m;
        if (t_w >= 10) begin
          m_err = 1;
          if (!wen) m_rdt = 0;
        end else if (wen) begin
          case (t_w)
            0: m_out = (m_out & ~t_m) | t_d;
            1: m_oe  = (m_oe  & ~t_m) | t_d;
            3: m_out = m_out | t_d;
            4: m_out = m_out & ~t_d;
            5: m_out = m_out ^ t_d;
            6: m_ien = (m_ien & ~t_m) | t_d;
            7: m_ren = (m_ren & ~t_m) | t_d;
            8: m_fen = (m_fen & ~t_m) | t_d;
            9: t_w1c = t_d;
            default: ;
          endcase
        end else begin
          case (t_w)
            0: m_rdt = m_out;
            1: m_rdt = m_oe;
            2: m_rdt = t_cur;
            6: m_rdt = m_ien;
            7: m_rdt = m_ren;
            8: m_rdt = m_fen;
            9: m_rdt = m_sts;
            default: m_rdt = 0;
          endcase
        end
      end
      m_sts  = (m_sts & ~t_w1c) | t_rise | t_fall;
      m_prev = t_cur;
      hist.push_front(gi);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    chk("rdy", {31'h0, rdy}, 32'h1);
    chk("rdy8", {31'h0, rdy8}, 32'h1);
    chk("model_rdt", rdt, m_rdt);
    chk("model_err", {31'h0, err}, {31'h0, m_err});
    chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
    chk("model_gpio_o", go, m_out);
    chk("model_gpio_e", ge, m_oe);
    chk("irq8_idle", {31'h0, irq8}, 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input bit t8, input bit w, input logic [5:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    if (t8) vld8 = 1'b1; else vld = 1'b1;
    wen = w; adr = a; ben = b; wdt = d;
    @(negedge clk);
    vld = 1'b0; vld8 = 1'b0; wen = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    xfer(1'b0, 1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input logic [5:0] a);
    xfer(1'b0, 1'b0, a, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] rst_adrs [4];

  initial begin
    vld = 0; vld8 = 0; wen = 0; adr = 0; ben = 0; wdt = 0; gi = 0; gi8 = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_gpio_o", go, 32'h0);
    chk("rst_gpio_e", ge, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdt", rdt, 32'h0);
    rst_adrs[0] = 6'h00; rst_adrs[1] = 6'h04; rst_adrs[2] = 6'h18; rst_adrs[3] = 6'h24;
    for (int i = 0; i < 4; i++) begin
      rd(rst_adrs[i]);
      chk("rd_reset", rdt, 32'h0);
      chk("rd_reset_err", {31'h0, err}, 32'h0);
    end

    // OUT and atomic aliases
    wr(6'h00, 32'h0000_00F0);
    wr(6'h0C, 32'h0000_000F);
    chk("out_set", go, 32'h0000_00FF);
    wr(6'h10, 32'h0000_0030);
    chk("out_clr", go, 32'h0000_00CF);
    wr(6'h14, 32'h0000_0101);
    chk("out_tgl", go, 32'h0000_01CE);
    xfer(1'b0, 1'b1, 6'h00, 4'b0010, 32'hAABB_CCDD);
    chk("out_ben", go, 32'h0000_CCCE);
    xfer(1'b0, 1'b1, 6'h14, 4'b0001, 32'hFFFF_FF00);
    chk("tgl_ben_zero_byte", go, 32'h0000_CCCE);
    rd(6'h00);
    chk("rd_out", rdt, 32'h0000_CCCE);
    rd(6'h0C);
    chk("rd_alias_zero", rdt, 32'h0);
    wr(6'h04, 32'h0000_FF00);
    chk("oe", ge, 32'h0000_FF00);

    // rising edge -> status -> irq latency, then W1C
    wr(6'h1C, 32'h1);
    wr(6'h18, 32'h1);
    gi[0] = 1'b1;
    idle(3);
    chk("irq_before", {31'h0, irq}, 32'h0);
    rd(6'h24);
    chk("sts_rise", rdt, 32'h1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    wr(6'h24, 32'h1);
    chk("irq_w1c_lag", {31'h0, irq}, 32'h1);
    idle(1);
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // falling edge with irq masked, then enable
    wr(6'h18, 32'h0);
    wr(6'h20, 32'h2);
    gi[1] = 1'b1;
    idle(5);
    gi[1] = 1'b0;
    idle(5);
    rd(6'h24);
    chk("sts_fall", rdt, 32'h2);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(6'h18, 32'h2);
    chk("irq_en_lag", {31'h0, irq}, 32'h0);
    idle(1);
    chk("irq_en_on", {31'h0, irq}, 32'h1);
    wr(6'h24, 32'h2);
    wr(6'h18, 32'h1);
    idle(2);
    chk("irq_off2", {31'h0, irq}, 32'h0);

    // W1C coinciding with a new rise: event wins
    gi[0] = 1'b0;
    idle(5);
    gi[0] = 1'b1;
    idle(5);
    chk("irq_set_again", {31'h0, irq}, 32'h1);
    gi[0] = 1'b0;
    idle(5);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    gi[0] = 1'b1;
    idle(2);
    wr(6'h24, 32'h1);
    idle(2);
    chk("irq_race", {31'h0, irq}, 32'h1);
    rd(6'h24);
    chk("sts_event_wins", rdt, 32'h1);
    rd(6'h08);
    chk("in_reg", rdt, 32'h1);

    // address errors
    rd(6'h00);
    chk("rd_out2", rdt, 32'h0000_CCCE);
    rd(6'h28);
    chk("err_rd", {31'h0, err}, 32'h1);
    chk("err_rd_data", rdt, 32'h0);
    idle(1);
    chk("err_pulse", {31'h0, err}, 32'h0);
    xfer(1'b0, 1'b1, 6'h3C, 4'hF, 32'hFFFF_FFFF);
    chk("err_wr", {31'h0, err}, 32'h1);
    chk("err_wr_rdt", rdt, 32'h0);
    chk("err_wr_out", go, 32'h0000_CCCE);
    rd(6'h00);
    chk("err_no_change", rdt, 32'h0000_CCCE);

    // narrow build
    xfer(1'b1, 1'b1, 6'h00, 4'hF, 32'hFFFF_FFFF);
    chk("gw8_gpio_o", {24'h0, go8}, 32'h0000_00FF);
    xfer(1'b1, 1'b0, 6'h00, 4'h0, 32'h0);
    chk("gw8_rd_out", rdt8, 32'h0000_00FF);
    xfer(1'b1, 1'b1, 6'h04, 4'hF, 32'h1234_5678);
    chk("gw8_oe", {24'h0, ge8}, 32'h0000_0078);
    gi8 = 8'hA5;
    xfer(1'b1, 1'b0, 6'h08, 4'h0, 32'h0);
    chk("gw8_in", rdt8, 32'h0000_00A5);
    chk("gw8_err", {31'h0, err8}, 32'h0);

    // reset in the middle of a read response
    vld = 1'b1; wen = 1'b0; adr = 6'h00; ben = 4'h0;
    @(posedge clk);
    #1;
    chk("rd_before_rst", rdt, 32'h0000_CCCE);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdt", rdt, 32'h0);
    chk("mid_rst_gpio_o", go, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
